// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the SPI-mapped I/O and RF front-end control block:
// register addresses, RF mode encoding and the RF pin bundle.
package io_ctrl_pkg;

  localparam logic [4:0] IOC_VERSION = 5'h00;
  localparam logic [4:0] IOC_LED     = 5'h01;
  localparam logic [4:0] IOC_PMOD    = 5'h02;
  localparam logic [4:0] IOC_STATUS  = 5'h03;
  localparam logic [4:0] IOC_RF_MODE = 5'h04;

  localparam logic [7:0] DEFAULT_VERSION = 8'h01;

  typedef enum logic [2:0] {
    RF_LOW_PWR    = 3'd0,
    RF_BYPASS     = 3'd1,
    RF_RX_LOWPASS = 3'd2,
    RF_RX_HIPASS  = 3'd3,
    RF_TX_LOWPASS = 3'd4,
    RF_TX_HIPASS  = 3'd5
  } rf_mode_e;

  typedef struct packed {
    logic rx_h_tx_l;
    logic tr_vc1;
    logic tr_vc2;
    logic shdn_rx_lna;
    logic shdn_tx_lna;
    logic mixer_en;
  } rf_pins_t;

  localparam rf_pins_t RF_PINS_LOW_PWR = 6'b111110;

endpackage

// File: rtl/rf_mode_decode.sv
// Combinational RF mode -> pin map; zero latency, no flow control.
// Unassigned encodings fall back to the low-power pin set.
module rf_mode_decode
  import io_ctrl_pkg::*;
(
  input  logic [2:0] mode,
  output rf_pins_t   pins
);

  always_comb begin
    pins = RF_PINS_LOW_PWR;
    case (rf_mode_e'(mode))
      RF_LOW_PWR:    pins = RF_PINS_LOW_PWR;
      RF_BYPASS:     pins = 6'b101110;
      RF_RX_LOWPASS: pins = 6'b110010;
      RF_RX_HIPASS:  pins = 6'b100011;
      RF_TX_LOWPASS: pins = 6'b010100;
      RF_TX_HIPASS:  pins = 6'b000101;
      default:       pins = RF_PINS_LOW_PWR;
    endcase
  end

endmodule

// File: rtl/rf_io_ctrl.sv
// Register-mapped LED/PMOD/RF switch control; writes land in one cycle, reads
// return one cycle after the fetch strobe; strobes are single-cycle, no stalls.
module rf_io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter logic [7:0] VERSION = DEFAULT_VERSION
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic [4:0] i_ioc,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  input  logic       i_cs,
  input  logic       i_fetch_cmd,
  input  logic       i_load_cmd,
  input  logic       i_button,
  input  logic [3:0] i_config,
  output logic       o_led0,
  output logic       o_led1,
  output logic [7:0] o_pmod,
  output logic       o_mixer_fm,
  output logic       o_mixer_en,
  output logic       o_rx_h_tx_l,
  output logic       o_rx_h_tx_l_b,
  output logic       o_tr_vc1,
  output logic       o_tr_vc1_b,
  output logic       o_tr_vc2,
  output logic       o_shdn_rx_lna,
  output logic       o_shdn_tx_lna
);

  logic       wr_en;
  logic       rd_en;
  logic [1:0] led_reg;
  logic [7:0] pmod_reg;
  logic [7:0] rf_mode_reg;
  logic [7:0] rf_mode_nxt;
  logic [7:0] rd_mux;
  logic [7:0] data_out_reg;
  logic       button_meta;
  logic       button_sync;
  logic [3:0] config_meta;
  logic [3:0] config_sync;
  rf_pins_t   rf_pins_nxt;
  rf_pins_t   rf_pins_q;
  logic       rx_h_tx_l_b_q;
  logic       tr_vc1_b_q;

  assign wr_en = i_cs && i_load_cmd;
  assign rd_en = i_cs && i_fetch_cmd;

  // Decode the value about to be stored so pins move on the same edge as the register.
  assign rf_mode_nxt = (wr_en && (i_ioc == IOC_RF_MODE)) ? i_data_in : rf_mode_reg;

  rf_mode_decode u_rf_mode_decode (
    .mode (rf_mode_nxt[2:0]),
    .pins (rf_pins_nxt)
  );

  always_comb begin
    rd_mux = 8'h00;
    case (i_ioc)
      IOC_VERSION: rd_mux = VERSION;
      IOC_LED:     rd_mux = {6'b0, led_reg};
      IOC_PMOD:    rd_mux = pmod_reg;
      IOC_STATUS:  rd_mux = {3'b0, button_sync, config_sync};
      IOC_RF_MODE: rd_mux = rf_mode_reg;
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      led_reg       <= 2'b00;
      pmod_reg      <= 8'h00;
      rf_mode_reg   <= 8'h00;
      data_out_reg  <= 8'h00;
      button_meta   <= 1'b0;
      button_sync   <= 1'b0;
      config_meta   <= 4'h0;
      config_sync   <= 4'h0;
      rf_pins_q     <= RF_PINS_LOW_PWR;
      rx_h_tx_l_b_q <= 1'b0;
      tr_vc1_b_q    <= 1'b0;
    end else begin
      button_meta <= i_button;
      button_sync <= button_meta;
      config_meta <= i_config;
      config_sync <= config_meta;

      if (wr_en) begin
        case (i_ioc)
          IOC_LED:  led_reg  <= i_data_in[1:0];
          IOC_PMOD: pmod_reg <= i_data_in;
          default:  ;
        endcase
      end
      rf_mode_reg   <= rf_mode_nxt;
      rf_pins_q     <= rf_pins_nxt;
      rx_h_tx_l_b_q <= ~rf_pins_nxt.rx_h_tx_l;
      tr_vc1_b_q    <= ~rf_pins_nxt.tr_vc1;

      // Mux reads pre-edge register state, so a same-cycle write returns the old value.
      if (rd_en) data_out_reg <= rd_mux;
    end
  end

  assign o_data_out    = data_out_reg;
  assign o_led0        = led_reg[0];
  assign o_led1        = led_reg[1];
  assign o_pmod        = pmod_reg;
  assign o_mixer_fm    = rf_mode_reg[7];
  assign o_mixer_en    = rf_pins_q.mixer_en;
  assign o_rx_h_tx_l   = rf_pins_q.rx_h_tx_l;
  assign o_rx_h_tx_l_b = rx_h_tx_l_b_q;
  assign o_tr_vc1      = rf_pins_q.tr_vc1;
  assign o_tr_vc1_b    = tr_vc1_b_q;
  assign o_tr_vc2      = rf_pins_q.tr_vc2;
  assign o_shdn_rx_lna = rf_pins_q.shdn_rx_lna;
  assign o_shdn_tx_lna = rf_pins_q.shdn_tx_lna;

endmodule

// File: tb/tb_rf_io_ctrl.sv
// Directed vector bench for rf_io_ctrl: one table row per clock cycle,
// plus hand-written reset sequences.
module tb_rf_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [4:0] ioc;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       cs, fetch_cmd, load_cmd, button;
  logic [3:0] cfg;
  logic       led0, led1, mixer_fm, mixer_en;
  logic [7:0] pmod;
  logic       rx_h_tx_l, rx_h_tx_l_b, tr_vc1, tr_vc1_b, tr_vc2;
  logic       shdn_rx_lna, shdn_tx_lna;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_io_ctrl #(.VERSION(8'h01)) dut (
    .i_sys_clk     (clk),
    .i_rst_b       (rst_b),
    .i_ioc         (ioc),
    .i_data_in     (data_in),
    .o_data_out    (data_out),
    .i_cs          (cs),
    .i_fetch_cmd   (fetch_cmd),
    .i_load_cmd    (load_cmd),
    .i_button      (button),
    .i_config      (cfg),
    .o_led0        (led0),
    .o_led1        (led1),
    .o_pmod        (pmod),
    .o_mixer_fm    (mixer_fm),
    .o_mixer_en    (mixer_en),
    .o_rx_h_tx_l   (rx_h_tx_l),
    .o_rx_h_tx_l_b (rx_h_tx_l_b),
    .o_tr_vc1      (tr_vc1),
    .o_tr_vc1_b    (tr_vc1_b),
    .o_tr_vc2      (tr_vc2),
    .o_shdn_rx_lna (shdn_rx_lna),
    .o_shdn_tx_lna (shdn_tx_lna)
  );

  // Pin order {rx_h_tx_l, tr_vc1, tr_vc2, shdn_rx_lna, shdn_tx_lna, mixer_en}
  localparam logic [5:0] P_LOW = 6'b111110;
  localparam logic [5:0] P_BYP = 6'b101110;
  localparam logic [5:0] P_RXL = 6'b110010;
  localparam logic [5:0] P_RXH = 6'b100011;
  localparam logic [5:0] P_TXL = 6'b010100;
  localparam logic [5:0] P_TXH = 6'b000101;

  typedef struct {
    logic       cs, ld, fe;
    logic [4:0] ioc;
    logic [7:0] din;
    logic       btn;
    logic [3:0] cfg;
    logic [7:0] e_dout;
    logic [1:0] e_led;
    logic [7:0] e_pmod;
    logic       e_fm;
    logic [5:0] e_pins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic l, logic f, logic [4:0] a, logic [7:0] d,
                              logic b, logic [3:0] g, logic [7:0] edo, logic [1:0] el,
                              logic [7:0] ep, logic efm, logic [5:0] epins);
    vec_t v;
    v.cs = c; v.ld = l; v.fe = f; v.ioc = a; v.din = d; v.btn = b; v.cfg = g;
    v.e_dout = edo; v.e_led = el; v.e_pmod = ep; v.e_fm = efm; v.e_pins = epins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_dout, input logic [1:0] e_led,
                         input logic [7:0] e_pmod, input logic e_fm, input logic [5:0] e_pins);
    logic [5:0] pins;
    pins = {rx_h_tx_l, tr_vc1, tr_vc2, shdn_rx_lna, shdn_tx_lna, mixer_en};
    chk({tag, " data_out"}, data_out, e_dout);
    chk({tag, " leds"}, {6'b0, led1, led0}, {6'b0, e_led});
    chk({tag, " pmod"}, pmod, e_pmod);
    chk({tag, " mixer_fm"}, {7'b0, mixer_fm}, {7'b0, e_fm});
    chk({tag, " rf_pins"}, {2'b0, pins}, {2'b0, e_pins});
    chk({tag, " rx_b"}, {7'b0, rx_h_tx_l_b}, {7'b0, ~e_pins[5]});
    chk({tag, " vc1_b"}, {7'b0, tr_vc1_b}, {7'b0, ~e_pins[4]});
  endtask

  task automatic drive(input logic c, input logic l, input logic f, input logic [4:0] a,
                       input logic [7:0] d);
    cs = c; load_cmd = l; fetch_cmd = f; ioc = a; data_in = d;
  endtask

  initial begin
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    button = 1'b0;
    cfg = 4'h0;

    //       cs  ld  fe  ioc    din    btn cfg    dout   led    pmod   fm  pins
    vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 0, 4'h0, 8'h00, 2'd0, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h01, 8'h03, 0, 4'h0, 8'h00, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h01, 8'h00, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(0, 1, 0, 5'h01, 8'h00, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(0, 0, 1, 5'h00, 8'h00, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h83, 0, 4'h0, 8'h03, 2'd3, 8'h00, 1, P_RXH));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h04, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_TXL));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h01, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_BYP));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h02, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_RXL));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h05, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_TXH));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h07, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h04, 8'h00, 0, 4'h0, 8'h07, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h06, 0, 4'h0, 8'h07, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h04, 8'h00, 0, 4'h0, 8'h06, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h00, 8'h00, 0, 4'h0, 8'h01, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h1F, 8'h00, 0, 4'h0, 8'h00, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h1F, 8'hFF, 0, 4'h0, 8'h00, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h00, 8'h55, 0, 4'h0, 8'h00, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h00, 8'h00, 0, 4'h0, 8'h01, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h01, 8'hFF, 0, 4'h0, 8'h01, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h01, 8'h00, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 0, 5'h04, 8'h78, 0, 4'h0, 8'h03, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h04, 8'h00, 0, 4'h0, 8'h78, 2'd3, 8'h00, 0, P_LOW));
    vecs.push_back(mk(1, 1, 1, 5'h02, 8'h5A, 0, 4'h0, 8'h00, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h02, 8'h00, 0, 4'h0, 8'h5A, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 1, 4'hA, 8'h5A, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h03, 8'h00, 1, 4'hA, 8'h00, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h03, 8'h00, 1, 4'hA, 8'h1A, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h03, 8'h00, 0, 4'h5, 8'h1A, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h03, 8'h00, 0, 4'h5, 8'h1A, 2'd3, 8'h5A, 0, P_LOW));
    vecs.push_back(mk(1, 0, 1, 5'h03, 8'h00, 0, 4'h5, 8'h05, 2'd3, 8'h5A, 0, P_LOW));

    // Reset held across clock edges.
    repeat (3) @(posedge clk);
    #1 chk_all("reset", 8'h00, 2'd0, 8'h00, 1'b0, P_LOW);
    @(negedge clk);
    rst_b = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].cs, vecs[i].ld, vecs[i].fe, vecs[i].ioc, vecs[i].din);
      button = vecs[i].btn;
      cfg    = vecs[i].cfg;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_led, vecs[i].e_pmod,
                 vecs[i].e_fm, vecs[i].e_pins);
    end

    // Reset asserted mid-transaction: immediate clear, strobe lost.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'h04, 8'h83);
    #1 rst_b = 1'b0;
    #1 chk_all("async_rst", 8'h00, 2'd0, 8'h00, 1'b0, P_LOW);
    @(posedge clk);
    #1 chk_all("rst_hold", 8'h00, 2'd0, 8'h00, 1'b0, P_LOW);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'h03, 8'h00);
    rst_b = 1'b1;
    @(posedge clk);
    // Synchronizer restarted from 0, so the first STATUS read after reset is 0.
    #1 chk_all("post_rst", 8'h00, 2'd0, 8'h00, 1'b0, P_LOW);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'h04, 8'h00);
    @(posedge clk);
    #1 chk("post_rst mode", data_out, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
